joker_regfile_ctrl: RTL

Parametrised command engine for Joker TV control traffic. It consumes command packets from the EP2 OUT buffer and executes batched register writes and reads against an internal N-register control file plus a read-only status window. Read results go into the EP1 IN reply buffer. It succeeds the fixed single-byte command handlers: one packet carries up to 255 register operations, and register count, status width and buffer read latency are parameters.

---
 rtl/joker_regfile_ctrl.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/joker_regfile_ctrl.sv
// Batched register read/write command engine for Joker TV control packets.
// Define JCTRL_ERR_REPLY_EN to answer bad packets with {0xFF, cmd}.
module joker_regfile_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int NUM_STAT = 4,
  parameter logic [8*NUM_REGS-1:0] RESET_VAL = '0,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  buf_out_hasdata,
  input  logic [9:0]            buf_out_len,
  input  logic [7:0]            buf_out_q,
  output logic [10:0]           buf_out_addr_o,
  output logic                  buf_out_arm,
  input  logic                  buf_out_arm_ack,
  input  logic                  usb_in_ready,
  output logic [10:0]           usb_in_addr_o,
  output logic [7:0]            usb_in_data_o,
  output logic                  usb_in_wren_o,
  output logic                  usb_in_commit,
  output logic [10:0]           usb_in_commit_len,
  input  logic                  usb_in_commit_ack,
  input  logic [8*NUM_STAT-1:0] status_i,
  output logic [8*NUM_REGS-1:0] regs_o,
  output logic [NUM_REGS-1:0]   reg_wr_strobe,
  output logic                  busy
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_CHECK  = 4'd2;
  localparam logic [3:0] S_WAITIN = 4'd3;
  localparam logic [3:0] S_WR     = 4'd4;
  localparam logic [3:0] S_RD     = 4'd5;
  localparam logic [3:0] S_COMMIT = 4'd6;
  localparam logic [3:0] S_WAITC  = 4'd7;
  localparam logic [3:0] S_ARM    = 4'd8;
  localparam logic [3:0] S_WAITA  = 4'd9;

  localparam logic [7:0] CMD_WR = 8'h30;
  localparam logic [7:0] CMD_RD = 8'h31;

  logic [3:0]            state_q, state_d;
  logic [10:0]           addr_q, addr_d;
  logic [2:0]            lat_q, lat_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [7:0]            n_q, n_d;
  logic [7:0]            k_q, k_d;
  logic                  ph_q, ph_d;
  logic [7:0]            wa_q, wa_d;
  logic                  err_q, err_d;
  logic [8*NUM_REGS-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]   strobe_q, strobe_d;
  logic                  wren_q, wren_d;
  logic [10:0]           iaddr_q, iaddr_d;
  logic [7:0]            idata_q, idata_d;
  logic                  commit_q, commit_d;
  logic [10:0]           clen_q, clen_d;
  logic                  arm_q, arm_d;
  logic                  cack_q, aack_q;

  logic                  smp;
  logic [10:0]           need_wr;
  logic [10:0]           need_rd;
  logic [10:0]           len11;
  logic [7:0]            rd_val;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    lat_d    = lat_q;
    cmd_d    = cmd_q;
    n_d      = n_q;
    k_d      = k_q;
    ph_d     = ph_q;
    wa_d     = wa_q;
    err_d    = err_q;
    regs_d   = regs_q;
    strobe_d = '0;
    wren_d   = 1'b0;
    iaddr_d  = iaddr_q;
    idata_d  = idata_q;
    commit_d = commit_q;
    clen_d   = clen_q;
    arm_d    = arm_q;

    smp     = (lat_q == 3'(RD_LAT));
    need_wr = 11'd2 + {2'b0, n_q, 1'b0};
    need_rd = 11'd2 + {3'b0, n_q};
    len11   = {1'b0, buf_out_len};

    // Read mux: later matches override, unmatched addresses read as 0
    rd_val = 8'h00;
    for (int i = 0; i < NUM_REGS; i++)
      if (buf_out_q == 8'(i)) rd_val = regs_q[8*i +: 8];
    for (int j = 0; j < NUM_STAT; j++)
      if (buf_out_q == 8'(NUM_REGS + j)) rd_val = status_i[8*j +: 8];

    unique case (state_q)
      S_IDLE: begin
        if (buf_out_hasdata) begin
          state_d = S_FETCH;
          addr_d  = '0;
          lat_d   = '0;
          k_d     = '0;
          ph_d    = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: begin
        if (smp) begin
          lat_d  = '0;
          addr_d = addr_q + 11'd1;
          if (addr_q == 11'd0) begin
            cmd_d = buf_out_q;
          end else begin
            n_d     = buf_out_q;
            state_d = S_CHECK;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_CHECK: begin
        if (cmd_q == CMD_WR && len11 >= need_wr) begin
          state_d = (n_q == 8'd0) ? S_ARM : S_WR;
        end else if (cmd_q == CMD_RD && len11 >= need_rd) begin
          state_d = S_WAITIN;
        end else begin
`ifdef JCTRL_ERR_REPLY_EN
          err_d   = 1'b1;
          state_d = S_WAITIN;
`else
          state_d = S_ARM;
`endif
        end
      end
      S_WAITIN: begin
        if (usb_in_ready) begin
          wren_d  = 1'b1;
          iaddr_d = 11'd0;
          idata_d = err_q ? 8'hFF : CMD_RD;
          state_d = (!err_q && n_q == 8'd0) ? S_COMMIT : S_RD;
        end
      end
      S_WR: begin
        if (smp) begin
          lat_d  = '0;
          addr_d = addr_q + 11'd1;
          if (!ph_q) begin
            wa_d = buf_out_q;
            ph_d = 1'b1;
          end else begin
            ph_d = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
              if (wa_q == 8'(i)) begin
                regs_d[8*i +: 8] = buf_out_q;
                strobe_d[i]      = 1'b1;
              end
            end
            k_d = k_q + 8'd1;
            if (k_q + 8'd1 == n_q) state_d = S_ARM;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_RD: begin
        if (err_q) begin
          wren_d  = 1'b1;
          iaddr_d = 11'd1;
          idata_d = cmd_q;
          state_d = S_COMMIT;
        end else if (smp) begin
          lat_d   = '0;
          addr_d  = addr_q + 11'd1;
          wren_d  = 1'b1;
          iaddr_d = 11'd1 + {3'b0, k_q};
          idata_d = rd_val;
          k_d     = k_q + 8'd1;
          if (k_q + 8'd1 == n_q) state_d = S_COMMIT;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      S_COMMIT: begin
        commit_d = 1'b1;
        clen_d   = err_q ? 11'd2 : 11'd1 + {3'b0, n_q};
        state_d  = S_WAITC;
      end
      S_WAITC: begin
        if (cack_q && !usb_in_commit_ack) begin
          commit_d = 1'b0;
          state_d  = S_ARM;
        end
      end
      S_ARM: begin
        arm_d   = 1'b1;
        state_d = S_WAITA;
      end
      S_WAITA: begin
        if (aack_q && !buf_out_arm_ack) begin
          arm_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      lat_q    <= '0;
      cmd_q    <= '0;
      n_q      <= '0;
      k_q      <= '0;
      ph_q     <= 1'b0;
      wa_q     <= '0;
      err_q    <= 1'b0;
      regs_q   <= RESET_VAL;
      strobe_q <= '0;
      wren_q   <= 1'b0;
      iaddr_q  <= '0;
      idata_q  <= '0;
      commit_q <= 1'b0;
      clen_q   <= '0;
      arm_q    <= 1'b0;
      cack_q   <= 1'b0;
      aack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      lat_q    <= lat_d;
      cmd_q    <= cmd_d;
      n_q      <= n_d;
      k_q      <= k_d;
      ph_q     <= ph_d;
      wa_q     <= wa_d;
      err_q    <= err_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      wren_q   <= wren_d;
      iaddr_q  <= iaddr_d;
      idata_q  <= idata_d;
      commit_q <= commit_d;
      clen_q   <= clen_d;
      arm_q    <= arm_d;
      cack_q   <= usb_in_commit_ack;
      aack_q   <= buf_out_arm_ack;
    end
  end

  assign buf_out_addr_o    = addr_q;
  assign buf_out_arm       = arm_q;
  assign usb_in_addr_o     = iaddr_q;
  assign usb_in_data_o     = idata_q;
  assign usb_in_wren_o     = wren_q;
  assign usb_in_commit     = commit_q;
  assign usb_in_commit_len = clen_q;
  assign regs_o            = regs_q;
  assign reg_wr_strobe     = strobe_q;
  assign busy              = (state_q != S_IDLE);

endmodule
